iod_delay_line_ctrl: RTL
========================

Name: iod_delay_line_ctrl

Overview:
- Sequences the dynamic delay line of one IOD lane (DDR4 address/command class, e.g. ACT_N) through its MOVE/DIRECTION/LOAD pins.
- Arbitrates between a training requester (absolute tap target, priority) and a VT-tracking requester (single ±1 step).
- Tracks the current tap, enforces a settle gap between moves, and flags out-of-range.
- Sits between the DDR PHY training logic and the IOD, clocked on the fabric clock.

Parameters:
- TAP_W, 7, tap counter width
- MAX_TAP, 127, highest legal tap; must be ≤ 2^TAP_W-1
- LOAD_TAP, 1, tap value after a LOAD; matches the IOD static delay value
- SETTLE_CYCLES, 4, idle cycles after each MOVE or LOAD pulse, ≥1

Ports:
- FAB_CLK  in  1  fabric clock; all logic on the rising edge
- SYNC_RST  in  1  synchronous, active-high reset
- LOAD_REQ  in  1  one-cycle pulse: reload the delay line to LOAD_TAP
- TRAIN_VALID  in  1  training request valid
- TRAIN_TARGET  in  TAP_W  absolute target tap
- TRAIN_READY  out  1  training request accepted this cycle
- TRAIN_DONE  out  1  one-cycle pulse: target reached, or aborted on range error
- VT_VALID  in  1  VT step request valid
- VT_DIR  in  1  1 = increment tap, 0 = decrement tap
- VT_ACK  out  1  one-cycle pulse: VT step done or rejected
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD
- DELAY_LINE_MOVE  out  1  to IOD; one-cycle pulse per tap
- DELAY_LINE_DIRECTION  out  1  to IOD; 1 = increment
- DELAY_LINE_LOAD  out  1  to IOD; one-cycle pulse
- CUR_TAP  out  TAP_W  tracked tap value
- BUSY  out  1  high whenever the FSM is not in IDLE
- OOR_ERR  out  1  sticky range error; cleared only by LOAD or SYNC_RST

Behaviour:
- Reset: all outputs 0 except CUR_TAP = LOAD_TAP. FSM goes to IDLE. SYNC_RST wins over every other input, including mid-sequence; no pulse is driven in the reset cycle.
- FSM states: IDLE, LOAD, STEP, SETTLE, FINISH.
- IDLE priority: LOAD_REQ, then TRAIN_VALID, then VT_VALID.
  - LOAD_REQ: go to LOAD.
  - TRAIN_VALID: TRAIN_READY=1 for that cycle; latch the target, clamped to MAX_TAP. If target == CUR_TAP, go to FINISH; else go to STEP.
  - VT_VALID: latch a target of CUR_TAP±1. If this would go below 0 or above MAX_TAP, the request is rejected: VT_ACK pulses next cycle, no MOVE, OOR_ERR unchanged.
- LOAD (1 cycle): DELAY_LINE_LOAD=1; CUR_TAP←LOAD_TAP; OOR_ERR←0. Then SETTLE.
- STEP (1 cycle): DELAY_LINE_MOVE=1; DELAY_LINE_DIRECTION = (target > CUR_TAP). DIRECTION is driven in the same cycle as MOVE and held until the next STEP. CUR_TAP moves ±1. Then SETTLE.
- SETTLE: counts SETTLE_CYCLES cycles.
  - If DELAY_LINE_OUT_OF_RANGE=1 during SETTLE: set OOR_ERR, abandon the target, go to FINISH.
  - On expiry: if CUR_TAP ≠ target, go to STEP; else go to FINISH.
- FINISH (1 cycle): pulse TRAIN_DONE or VT_ACK for the owning request (none after a LOAD). Then IDLE.
- No preemption: requests arriving while BUSY are held by the requester until served. LOAD_REQ while BUSY is dropped.
- Latency: a training move of N taps takes N·(1+SETTLE_CYCLES)+2 cycles from TRAIN_READY to TRAIN_DONE. Zero-distance request: TRAIN_DONE 2 cycles after TRAIN_READY.
- MOVE and LOAD never assert in the same cycle. At least SETTLE_CYCLES cycles separate any two pulses.

Optional Feature:
- Macro: IOD_DLY_VT_TRACK_EN.
- Defined: VT requester active as described above.
- Undefined: VT_VALID and VT_DIR are ignored, VT_ACK is tied 0, and the VT arbitration branch is removed. The training path is unchanged.

Test Plan:
- Reset → CUR_TAP=1, all pulse outputs 0. LOAD_REQ → LOAD pulse, BUSY for 1+SETTLE_CYCLES cycles, CUR_TAP=1.
- TRAIN_TARGET=5 from tap 1 → exactly 4 MOVE pulses with DIRECTION=1, each 5 cycles apart; TRAIN_DONE at cycle 22 after TRAIN_READY; CUR_TAP=5.
- TRAIN_TARGET=200 (clamped to 127), DELAY_LINE_OUT_OF_RANGE forced high after the 10th MOVE → OOR_ERR=1, TRAIN_DONE pulses, CUR_TAP=11; a following LOAD_REQ clears OOR_ERR.
- TRAIN_VALID and VT_VALID asserted in the same cycle → training served first; VT_ACK follows after TRAIN_DONE.
- At tap 0, VT_VALID with VT_DIR=0 → no MOVE, VT_ACK pulses, CUR_TAP stays 0. With IOD_DLY_VT_TRACK_EN undefined → VT_ACK never asserts.
- SYNC_RST asserted mid-SETTLE during a 3-tap move → next cycle IDLE, CUR_TAP=1, no further MOVE, TRAIN_DONE not pulsed.

Source files
------------

// File: rtl/iod_delay_line_ctrl_if.sv
// iod_delay_line_ctrl_if: requester and IOD-side bundle of the delay-line controller.
// master = training/VT requesters plus IOD, slave = the controller itself.
interface iod_delay_line_ctrl_if #(
    parameter int TAP_W = 7
);
    logic             LOAD_REQ;
    logic             TRAIN_VALID;
    logic [TAP_W-1:0] TRAIN_TARGET;
    logic             TRAIN_READY;
    logic             TRAIN_DONE;
    logic             VT_VALID;
    logic             VT_DIR;
    logic             VT_ACK;
    logic             DELAY_LINE_OUT_OF_RANGE;
    logic             DELAY_LINE_MOVE;
    logic             DELAY_LINE_DIRECTION;
    logic             DELAY_LINE_LOAD;
    logic [TAP_W-1:0] CUR_TAP;
    logic             BUSY;
    logic             OOR_ERR;

    modport master (
        output LOAD_REQ, TRAIN_VALID, TRAIN_TARGET,
        output VT_VALID, VT_DIR, DELAY_LINE_OUT_OF_RANGE,
        input  TRAIN_READY, TRAIN_DONE, VT_ACK,
        input  DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
        input  DELAY_LINE_LOAD, CUR_TAP, BUSY, OOR_ERR
    );

    modport slave (
        input  LOAD_REQ, TRAIN_VALID, TRAIN_TARGET,
        input  VT_VALID, VT_DIR, DELAY_LINE_OUT_OF_RANGE,
        output TRAIN_READY, TRAIN_DONE, VT_ACK,
        output DELAY_LINE_MOVE, DELAY_LINE_DIRECTION,
        output DELAY_LINE_LOAD, CUR_TAP, BUSY, OOR_ERR
    );
endinterface

// File: rtl/iod_delay_line_ctrl.sv
// iod_delay_line_ctrl: sequences one IOD delay line via MOVE/DIRECTION/LOAD.
// Define IOD_DLY_VT_TRACK_EN to enable the single-step VT-tracking requester.
module iod_delay_line_ctrl #(
    parameter int TAP_W         = 7,
    parameter int MAX_TAP       = 127,
    parameter int LOAD_TAP      = 1,
    parameter int SETTLE_CYCLES = 4
) (
    input logic                  FAB_CLK,
    input logic                  SYNC_RST,
    iod_delay_line_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, STEP, SETTLE, FINISH} state_t;

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [TAP_W-1:0] MAX_T    = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0] LOAD_T   = TAP_W'(LOAD_TAP);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    state_t           state_q, state_d;
    logic [TAP_W-1:0] cur_q, tgt_q, train_tgt;
    logic [CNT_W-1:0] cnt_q;
    logic             own_train_q, dir_q, oor_q, done_q;
    logic             train_go, dir, owned;

    assign train_tgt = (bus.TRAIN_TARGET > MAX_T) ? MAX_T : bus.TRAIN_TARGET;
    assign train_go  = (state_q == IDLE) && !bus.LOAD_REQ && bus.TRAIN_VALID;
    assign dir       = (state_q == STEP) ? (tgt_q > cur_q) : dir_q;

`ifdef IOD_DLY_VT_TRACK_EN
    logic             own_vt_q, ack_q, vt_go, vt_rej;
    logic [TAP_W-1:0] vt_tgt;

    // VT_VALID is still high while its ACK shows; never serve it twice.
    assign vt_go  = (state_q == IDLE) && !bus.LOAD_REQ && !bus.TRAIN_VALID &&
                    bus.VT_VALID && !ack_q;
    assign vt_rej = bus.VT_DIR ? (cur_q == MAX_T) : (cur_q == '0);
    assign vt_tgt = bus.VT_DIR ? cur_q + 1'b1 : cur_q - 1'b1;
    assign owned  = own_train_q || own_vt_q;

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            own_vt_q <= 1'b0;
            ack_q    <= 1'b0;
        end else begin
            ack_q <= (vt_go && vt_rej) || ((state_q == FINISH) && own_vt_q);
            if (state_q == IDLE)
                own_vt_q <= vt_go && !vt_rej;
        end
    end
`else
    logic unused_vt;
    assign unused_vt = bus.VT_VALID ^ bus.VT_DIR;
    assign owned     = own_train_q;
`endif

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.LOAD_REQ)
                    state_d = LOAD;
                else if (train_go)
                    state_d = (train_tgt == cur_q) ? FINISH : STEP;
`ifdef IOD_DLY_VT_TRACK_EN
                else if (vt_go && !vt_rej)
                    state_d = STEP;
`endif
            end
            LOAD:   state_d = SETTLE;
            STEP:   state_d = SETTLE;
            SETTLE: begin
                if (bus.DELAY_LINE_OUT_OF_RANGE)
                    state_d = FINISH;
                else if (cnt_q == '0) begin
                    if (cur_q != tgt_q)
                        state_d = STEP;
                    else
                        state_d = owned ? FINISH : IDLE;
                end
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            cur_q       <= LOAD_T;
            tgt_q       <= LOAD_T;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            oor_q       <= 1'b0;
            own_train_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= (state_q == FINISH) && own_train_q;
            dir_q  <= dir;
            unique case (state_q)
                IDLE: begin
                    own_train_q <= train_go;
                    if (train_go)
                        tgt_q <= train_tgt;
`ifdef IOD_DLY_VT_TRACK_EN
                    else if (vt_go && !vt_rej)
                        tgt_q <= vt_tgt;
`endif
                end
                LOAD: begin
                    cur_q <= LOAD_T;
                    tgt_q <= LOAD_T;
                    oor_q <= 1'b0;
                    cnt_q <= CNT_INIT;
                end
                STEP: begin
                    cur_q <= dir ? cur_q + 1'b1 : cur_q - 1'b1;
                    cnt_q <= CNT_INIT;
                end
                SETTLE: begin
                    if (bus.DELAY_LINE_OUT_OF_RANGE)
                        oor_q <= 1'b1;
                    else if (cnt_q != '0)
                        cnt_q <= cnt_q - 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Pulses are suppressed while reset is held so none escapes in that cycle.
    always_comb begin
        bus.DELAY_LINE_MOVE      = (state_q == STEP) && !SYNC_RST;
        bus.DELAY_LINE_LOAD      = (state_q == LOAD) && !SYNC_RST;
        bus.DELAY_LINE_DIRECTION = dir;
        bus.TRAIN_READY          = train_go && !SYNC_RST;
        bus.TRAIN_DONE           = done_q && !SYNC_RST;
        bus.BUSY                 = (state_q != IDLE);
        bus.CUR_TAP              = cur_q;
        bus.OOR_ERR              = oor_q;
`ifdef IOD_DLY_VT_TRACK_EN
        bus.VT_ACK               = ack_q && !SYNC_RST;
`else
        bus.VT_ACK               = 1'b0;
`endif
    end
endmodule
